regfl_wr_arb: RTL

//  Write-port controller for the 4x8 register file. Shares the single write

---
 rtl/regfl_wr_arb.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/regfl_wr_arb.sv
`default_nettype none
// ============================================================================
//  Module   : regfl_wr_arb
//  Purpose  : Write-port controller for a small register file. Two requesters
//             share the single write port through a round-robin arbiter. A
//             clear sweep writes CLR_VAL to every entry after reset and
//             whenever clr_req is seen while arbitrating. The read port of the
//             register file is not touched.
//  Ports    : clk, rst          - clock (rising edge), synchronous active-high
//                                 reset
//             clr_req           - start a clear sweep (level, sampled in ARB)
//             req0/addr0/data0  - requester 0 write request, address, data
//             gnt0              - one-cycle grant, coincides with its write
//             req1/addr1/data1  - requester 1 write request, address, data
//             gnt1              - one-cycle grant for requester 1
//             wr_e/wr_addr/wr_data - register file write port
//             busy              - high while the clear sweep runs
//  Revision : 1.0 - initial release
// ============================================================================
module regfl_wr_arb #(
    parameter int             W       = 8,
    parameter int             AW      = 2,
    parameter logic [W-1:0]   CLR_VAL = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr_req,
    input  logic            req0,
    input  logic [AW-1:0]   addr0,
    input  logic [W-1:0]    data0,
    output logic            gnt0,
    input  logic            req1,
    input  logic [AW-1:0]   addr1,
    input  logic [W-1:0]    data1,
    output logic            gnt1,
    output logic            wr_e,
    output logic [AW-1:0]   wr_addr,
    output logic [W-1:0]    wr_data,
    output logic            busy
);

    localparam int            c_NREG = 2 ** AW;
    localparam logic [AW-1:0] c_LAST = AW'(c_NREG - 1);

    typedef enum logic [0:0] {
        ST_SWEEP = 1'b0,
        ST_ARB   = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_t          r_state;
    logic [AW-1:0]   r_cnt;
    logic            r_ptr;      // 0: requester 0 wins a tie, 1: requester 1
    logic            r_gnt0;
    logic            r_gnt1;
    logic            r_wr_e;
    logic [AW-1:0]   r_wr_addr;
    logic [W-1:0]    r_wr_data;

    // Next-state values
    state_t          w_state_nxt;
    logic [AW-1:0]   w_cnt_nxt;
    logic            w_ptr_nxt;
    logic            w_gnt0_nxt;
    logic            w_gnt1_nxt;
    logic            w_wr_e_nxt;
    logic [AW-1:0]   w_wr_addr_nxt;
    logic [W-1:0]    w_wr_data_nxt;

    // ------------------------------------------------------------------
    // Eligibility and selection
    // A requester whose grant is currently high is masked: it has not yet
    // had a cycle to drop req, so serving it again would repeat its write.
    // ------------------------------------------------------------------
    logic w_elig0;
    logic w_elig1;
    logic w_sel0;
    logic w_sel1;

    assign w_elig0 = req0 & ~r_gnt0;
    assign w_elig1 = req1 & ~r_gnt1;

    // On a tie the pointer decides; otherwise the lone eligible one wins.
    assign w_sel0  = w_elig0 & (~w_elig1 | ~r_ptr);
    assign w_sel1  = w_elig1 & (~w_elig0 |  r_ptr);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_SWEEP;
            r_cnt     <= '0;
            r_ptr     <= 1'b0;
            r_gnt0    <= 1'b0;
            r_gnt1    <= 1'b0;
            r_wr_e    <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_ptr     <= w_ptr_nxt;
            r_gnt0    <= w_gnt0_nxt;
            r_gnt1    <= w_gnt1_nxt;
            r_wr_e    <= w_wr_e_nxt;
            r_wr_addr <= w_wr_addr_nxt;
            r_wr_data <= w_wr_data_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // Grants and write enable default low so they only ever pulse for one
    // cycle; address, data and pointer hold unless a write is issued.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_ptr_nxt     = r_ptr;
        w_gnt0_nxt    = 1'b0;
        w_gnt1_nxt    = 1'b0;
        w_wr_e_nxt    = 1'b0;
        w_wr_addr_nxt = r_wr_addr;
        w_wr_data_nxt = r_wr_data;

        case (r_state)
            ST_SWEEP: begin
                // One clear write per cycle; requests and clr_req are ignored.
                w_wr_e_nxt    = 1'b1;
                w_wr_addr_nxt = r_cnt;
                w_wr_data_nxt = CLR_VAL;
                if (r_cnt == c_LAST) begin
                    // The final write and the drop of busy share a cycle.
                    w_state_nxt = ST_ARB;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + AW'(1);
                end
            end

            ST_ARB: begin
                if (clr_req) begin
                    // Nothing is granted on the edge that enters the sweep.
                    w_state_nxt = ST_SWEEP;
                    w_cnt_nxt   = '0;
                end else if (w_sel0) begin
                    w_wr_e_nxt    = 1'b1;
                    w_wr_addr_nxt = addr0;
                    w_wr_data_nxt = data0;
                    w_gnt0_nxt    = 1'b1;
                    w_ptr_nxt     = 1'b1;
                end else if (w_sel1) begin
                    w_wr_e_nxt    = 1'b1;
                    w_wr_addr_nxt = addr1;
                    w_wr_data_nxt = data1;
                    w_gnt1_nxt    = 1'b1;
                    w_ptr_nxt     = 1'b0;
                end
            end

            default: begin
                w_state_nxt = ST_SWEEP;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign gnt0    = r_gnt0;
    assign gnt1    = r_gnt1;
    assign wr_e    = r_wr_e;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
    assign busy    = (r_state == ST_SWEEP);

endmodule
`default_nettype wire
